// File: rtl/rs_param.sv
// rs_param -- dual-dispatch reservation station with age-ordered issue.
//
// Purpose: holds up to DEPTH renamed instructions. Operands wait for their
// tags on NUM_CDB broadcast buses. The oldest entry with both operands
// ready is presented for issue. Each entry keeps a relative age rank: 0 is
// the oldest busy entry. When an entry leaves, every younger rank shifts
// down by one.
//
// Ports:
//   clk, reset (async, active-low)
//   disp_en/v1/v2/tag1/tag2/dst/dst_tag/val1/val2 : two dispatch lanes (lane 0 older)
//   cdb_we/cdb_tag/cdb_val                        : result broadcast buses
//   flush                                         : synchronous squash of all entries
//   iss_valid/iss_ready/iss_dst/iss_dst_tag/iss_val1/iss_val2 : issue handshake
//   stall                                         : fewer than two free entries
//   occupancy                                     : busy-entry count
//
// Configuration macro RS_BYPASS_EN: when defined, a dispatched operand that
// is still waiting picks up a matching same-cycle broadcast as it is written.
module rs_param #(
   parameter int DEPTH   = 8,
   parameter int TAG_W   = 5,
   parameter int DATA_W  = 32,
   parameter int NUM_CDB = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  disp_en,
   input  logic [1:0]                  disp_v1,
   input  logic [1:0]                  disp_v2,
   input  logic [2*TAG_W-1:0]          disp_tag1,
   input  logic [2*TAG_W-1:0]          disp_tag2,
   input  logic [9:0]                  disp_dst,
   input  logic [2*TAG_W-1:0]          disp_dst_tag,
   input  logic [2*DATA_W-1:0]         disp_val1,
   input  logic [2*DATA_W-1:0]         disp_val2,
   input  logic [NUM_CDB-1:0]          cdb_we,
   input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0]   cdb_val,
   input  logic                        flush,
   output logic                        iss_valid,
   input  logic                        iss_ready,
   output logic [4:0]                  iss_dst,
   output logic [TAG_W-1:0]            iss_dst_tag,
   output logic [DATA_W-1:0]           iss_val1,
   output logic [DATA_W-1:0]           iss_val2,
   output logic                        stall,
   output logic [$clog2(DEPTH):0]      occupancy
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = IDX_W + 1;

   logic              r_busy [DEPTH];
   logic              r_v1   [DEPTH];
   logic              r_v2   [DEPTH];
   logic [TAG_W-1:0]  r_tag1 [DEPTH];
   logic [TAG_W-1:0]  r_tag2 [DEPTH];
   logic [DATA_W-1:0] r_val1 [DEPTH];
   logic [DATA_W-1:0] r_val2 [DEPTH];
   logic [4:0]        r_dst  [DEPTH];
   logic [TAG_W-1:0]  r_dtag [DEPTH];
   logic [IDX_W-1:0]  r_rank [DEPTH];
   logic [OCC_W-1:0]  r_occ;

   // Broadcast match: {hit, value}. Scanning from the highest bus down lets
   // the lowest-index matching bus have the final word.
   function automatic logic [DATA_W:0] f_cdb(
      input logic [TAG_W-1:0]          tag,
      input logic [NUM_CDB-1:0]        we,
      input logic [NUM_CDB*TAG_W-1:0]  tags,
      input logic [NUM_CDB*DATA_W-1:0] vals
   );
      logic [DATA_W:0] res;
      res = '0;
      for (int b = NUM_CDB - 1; b >= 0; b--) begin
         if (we[b] && (tags[b*TAG_W +: TAG_W] == tag))
            res = {1'b1, vals[b*DATA_W +: DATA_W]};
      end
      return res;
   endfunction

   // ---------------- wakeup of stored operands ----------------
   logic [DATA_W:0] w_wake1 [DEPTH];
   logic [DATA_W:0] w_wake2 [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
         assign w_wake1[gi] = f_cdb(r_tag1[gi], cdb_we, cdb_tag, cdb_val);
         assign w_wake2[gi] = f_cdb(r_tag2[gi], cdb_we, cdb_tag, cdb_val);
      end
   endgenerate

   // ---------------- dispatched operand values ----------------
   logic              w_dv1   [2];
   logic              w_dv2   [2];
   logic [DATA_W-1:0] w_dval1 [2];
   logic [DATA_W-1:0] w_dval2 [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
`ifdef RS_BYPASS_EN
         logic [DATA_W:0] w_byp1;
         logic [DATA_W:0] w_byp2;
         assign w_byp1 = f_cdb(disp_tag1[gi*TAG_W +: TAG_W], cdb_we, cdb_tag, cdb_val);
         assign w_byp2 = f_cdb(disp_tag2[gi*TAG_W +: TAG_W], cdb_we, cdb_tag, cdb_val);
         assign w_dv1[gi]   = disp_v1[gi] | w_byp1[DATA_W];
         assign w_dv2[gi]   = disp_v2[gi] | w_byp2[DATA_W];
         assign w_dval1[gi] = (!disp_v1[gi] && w_byp1[DATA_W]) ? w_byp1[DATA_W-1:0]
                                                               : disp_val1[gi*DATA_W +: DATA_W];
         assign w_dval2[gi] = (!disp_v2[gi] && w_byp2[DATA_W]) ? w_byp2[DATA_W-1:0]
                                                               : disp_val2[gi*DATA_W +: DATA_W];
`else
         assign w_dv1[gi]   = disp_v1[gi];
         assign w_dv2[gi]   = disp_v2[gi];
         assign w_dval1[gi] = disp_val1[gi*DATA_W +: DATA_W];
         assign w_dval2[gi] = disp_val2[gi*DATA_W +: DATA_W];
`endif
      end
   endgenerate

   // ---------------- free-slot search (current busy bits only) ----------------
   // The search looks only at this cycle's busy bits. An entry freed by
   // this cycle's issue is therefore never handed out in the same cycle.
   logic [IDX_W-1:0] w_free0, w_free1;

   always_comb begin
      logic got0, got1;
      got0    = 1'b0;
      got1    = 1'b0;
      w_free0 = '0;
      w_free1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!r_busy[i]) begin
            if (!got0) begin
               w_free0 = IDX_W'(i);
               got0    = 1'b1;
            end else if (!got1) begin
               w_free1 = IDX_W'(i);
               got1    = 1'b1;
            end
         end
      end
   end

   // ---------------- oldest-ready select ----------------
   logic             w_iss_hit;
   logic [IDX_W-1:0] w_iss_idx, w_iss_rank;

   always_comb begin
      w_iss_hit  = 1'b0;
      w_iss_idx  = '0;
      w_iss_rank = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_busy[i] && r_v1[i] && r_v2[i] && (!w_iss_hit || (r_rank[i] < w_iss_rank))) begin
            w_iss_hit  = 1'b1;
            w_iss_idx  = IDX_W'(i);
            w_iss_rank = r_rank[i];
         end
      end
   end

   assign iss_valid   = w_iss_hit;
   assign iss_dst     = w_iss_hit ? r_dst[w_iss_idx]  : '0;
   assign iss_dst_tag = w_iss_hit ? r_dtag[w_iss_idx] : '0;
   assign iss_val1    = w_iss_hit ? r_val1[w_iss_idx] : '0;
   assign iss_val2    = w_iss_hit ? r_val2[w_iss_idx] : '0;
   assign stall       = (r_occ > OCC_W'(DEPTH - 2));
   assign occupancy   = r_occ;

   // ---------------- dispatch / issue control ----------------
   logic             w_wr0, w_wr1, w_fire;
   logic [IDX_W-1:0] w_slot1, w_rank0, w_rank1;

   assign w_wr0   = !stall && !flush && disp_en[0];
   assign w_wr1   = !stall && !flush && disp_en[1];
   assign w_slot1 = disp_en[0] ? w_free1 : w_free0;
   assign w_fire  = w_iss_hit && iss_ready && !flush;
   // New entries rank behind every entry that survives this edge.
   assign w_rank0 = r_occ[IDX_W-1:0] - IDX_W'(w_fire);
   assign w_rank1 = w_rank0 + IDX_W'(w_wr0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_busy[i] <= 1'b0;
            r_v1[i]   <= 1'b0;
            r_v2[i]   <= 1'b0;
            r_tag1[i] <= '0;
            r_tag2[i] <= '0;
            r_val1[i] <= '0;
            r_val2[i] <= '0;
            r_dst[i]  <= '0;
            r_dtag[i] <= '0;
            r_rank[i] <= '0;
         end
         r_occ <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_busy[i] <= 1'b0;
            r_v1[i]   <= 1'b0;
            r_v2[i]   <= 1'b0;
            r_rank[i] <= '0;
         end
         r_occ <= '0;
      end else begin
         r_occ <= r_occ + OCC_W'(w_wr0) + OCC_W'(w_wr1) - OCC_W'(w_fire);
         for (int i = 0; i < DEPTH; i++) begin
            if (r_busy[i]) begin
               if (!r_v1[i] && w_wake1[i][DATA_W]) begin
                  r_v1[i]   <= 1'b1;
                  r_val1[i] <= w_wake1[i][DATA_W-1:0];
               end
               if (!r_v2[i] && w_wake2[i][DATA_W]) begin
                  r_v2[i]   <= 1'b1;
                  r_val2[i] <= w_wake2[i][DATA_W-1:0];
               end
               if (w_fire && (r_rank[i] > w_iss_rank))
                  r_rank[i] <= r_rank[i] - IDX_W'(1);
            end
         end
         if (w_fire)
            r_busy[w_iss_idx] <= 1'b0;
         if (w_wr0) begin
            r_busy[w_free0] <= 1'b1;
            r_v1[w_free0]   <= w_dv1[0];
            r_v2[w_free0]   <= w_dv2[0];
            r_tag1[w_free0] <= disp_tag1[0 +: TAG_W];
            r_tag2[w_free0] <= disp_tag2[0 +: TAG_W];
            r_val1[w_free0] <= w_dval1[0];
            r_val2[w_free0] <= w_dval2[0];
            r_dst[w_free0]  <= disp_dst[4:0];
            r_dtag[w_free0] <= disp_dst_tag[0 +: TAG_W];
            r_rank[w_free0] <= w_rank0;
         end
         if (w_wr1) begin
            r_busy[w_slot1] <= 1'b1;
            r_v1[w_slot1]   <= w_dv1[1];
            r_v2[w_slot1]   <= w_dv2[1];
            r_tag1[w_slot1] <= disp_tag1[TAG_W +: TAG_W];
            r_tag2[w_slot1] <= disp_tag2[TAG_W +: TAG_W];
            r_val1[w_slot1] <= w_dval1[1];
            r_val2[w_slot1] <= w_dval2[1];
            r_dst[w_slot1]  <= disp_dst[9:5];
            r_dtag[w_slot1] <= disp_dst_tag[TAG_W +: TAG_W];
            r_rank[w_slot1] <= w_rank1;
         end
      end
   end

endmodule

// File: tb/tb_rs_param.sv
// tb_rs_param -- scoreboard bench for rs_param.
// The reference model keeps the station as an age-ordered list of
// instructions. For each cycle the driver pushes the expected status. It
// also pushes every instruction the model expects to issue. A monitor pops
// these records and compares them with what the DUT presents.
`timescale 1ns/1ps
module tb_rs_param;
   localparam int DEPTH   = 8;
   localparam int TAG_W   = 5;
   localparam int DATA_W  = 32;
   localparam int NUM_CDB = 4;
   localparam int OCC_W   = $clog2(DEPTH) + 1;

   logic                        clk = 1'b0;
   logic                        reset;
   logic [1:0]                  disp_en, disp_v1, disp_v2;
   logic [2*TAG_W-1:0]          disp_tag1, disp_tag2, disp_dst_tag;
   logic [9:0]                  disp_dst;
   logic [2*DATA_W-1:0]         disp_val1, disp_val2;
   logic [NUM_CDB-1:0]          cdb_we;
   logic [NUM_CDB*TAG_W-1:0]    cdb_tag;
   logic [NUM_CDB*DATA_W-1:0]   cdb_val;
   logic                        flush, iss_ready;
   logic                        iss_valid, stall;
   logic [4:0]                  iss_dst;
   logic [TAG_W-1:0]            iss_dst_tag;
   logic [DATA_W-1:0]           iss_val1, iss_val2;
   logic [OCC_W-1:0]            occupancy;

   always #5 clk = ~clk;

   rs_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) dut (
      .clk(clk), .reset(reset),
      .disp_en(disp_en), .disp_v1(disp_v1), .disp_v2(disp_v2),
      .disp_tag1(disp_tag1), .disp_tag2(disp_tag2), .disp_dst(disp_dst),
      .disp_dst_tag(disp_dst_tag), .disp_val1(disp_val1), .disp_val2(disp_val2),
      .cdb_we(cdb_we), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .flush(flush),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_dst(iss_dst),
      .iss_dst_tag(iss_dst_tag), .iss_val1(iss_val1), .iss_val2(iss_val2),
      .stall(stall), .occupancy(occupancy)
   );

   typedef struct packed {
      logic [4:0]        dst;
      logic [TAG_W-1:0]  dtag, t1, t2;
      logic              v1, v2;
      logic [DATA_W-1:0] a, b;
   } ent_t;

   typedef struct packed {
      logic              valid;
      logic [31:0]       occ;
      logic              stall;
      logic [4:0]        dst;
      logic [TAG_W-1:0]  dtag;
      logic [DATA_W-1:0] a, b;
   } stat_t;

   ent_t  m_q[$];     // model station, oldest first
   stat_t stat_q[$];  // expected per-cycle status
   ent_t  iss_q[$];   // expected issue stream

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W:0] bus_lookup(input logic [TAG_W-1:0] t);
      for (int b = 0; b < NUM_CDB; b++)
         if (cdb_we[b] && (cdb_tag[b*TAG_W +: TAG_W] == t))
            return {1'b1, cdb_val[b*DATA_W +: DATA_W]};
      return '0;
   endfunction

   // One cycle of the reference model, evaluated from the inputs about to be applied.
   task automatic model_step();
      stat_t s;
      ent_t  e;
      int    k;
      logic  fire;
      logic [DATA_W:0] h;
      k = -1;
      foreach (m_q[i]) if (k < 0 && m_q[i].v1 && m_q[i].v2) k = i;
      s       = '0;
      s.valid = (k >= 0);
      s.occ   = 32'(m_q.size());
      s.stall = (m_q.size() > DEPTH - 2);
      if (k >= 0) begin
         s.dst  = m_q[k].dst;
         s.dtag = m_q[k].dtag;
         s.a    = m_q[k].a;
         s.b    = m_q[k].b;
      end
      stat_q.push_back(s);
      fire = s.valid && iss_ready && !flush;
      if (fire) iss_q.push_back(m_q[k]);
      if (flush) begin
         m_q.delete();
         return;
      end
      for (int i = 0; i < m_q.size(); i++) begin
         e = m_q[i];
         if (!e.v1) begin
            h = bus_lookup(e.t1);
            if (h[DATA_W]) begin e.v1 = 1'b1; e.a = h[DATA_W-1:0]; end
         end
         if (!e.v2) begin
            h = bus_lookup(e.t2);
            if (h[DATA_W]) begin e.v2 = 1'b1; e.b = h[DATA_W-1:0]; end
         end
         m_q[i] = e;
      end
      if (fire) m_q.delete(k);
      if (!s.stall) begin
         for (int l = 0; l < 2; l++) begin
            if (disp_en[l]) begin
               e.dst  = disp_dst[l*5 +: 5];
               e.dtag = disp_dst_tag[l*TAG_W +: TAG_W];
               e.t1   = disp_tag1[l*TAG_W +: TAG_W];
               e.t2   = disp_tag2[l*TAG_W +: TAG_W];
               e.v1   = disp_v1[l];
               e.v2   = disp_v2[l];
               e.a    = disp_val1[l*DATA_W +: DATA_W];
               e.b    = disp_val2[l*DATA_W +: DATA_W];
`ifdef RS_BYPASS_EN
               if (!e.v1) begin
                  h = bus_lookup(e.t1);
                  if (h[DATA_W]) begin e.v1 = 1'b1; e.a = h[DATA_W-1:0]; end
               end
               if (!e.v2) begin
                  h = bus_lookup(e.t2);
                  if (h[DATA_W]) begin e.v2 = 1'b1; e.b = h[DATA_W-1:0]; end
               end
`endif
               m_q.push_back(e);
            end
         end
      end
   endtask

   task automatic idle();
      disp_en = '0; disp_v1 = '0; disp_v2 = '0;
      disp_tag1 = '0; disp_tag2 = '0; disp_dst = '0; disp_dst_tag = '0;
      disp_val1 = '0; disp_val2 = '0;
      cdb_we = '0; cdb_tag = '0; cdb_val = '0;
      flush = 1'b0; iss_ready = 1'b0;
   endtask

   task automatic set_lane(input int l, input logic v1, input logic [TAG_W-1:0] t1,
                           input logic [DATA_W-1:0] a, input logic v2,
                           input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] b,
                           input logic [TAG_W-1:0] dtag);
      disp_en[l] = 1'b1;
      disp_v1[l] = v1;
      disp_v2[l] = v2;
      disp_tag1[l*TAG_W +: TAG_W]    = t1;
      disp_tag2[l*TAG_W +: TAG_W]    = t2;
      disp_val1[l*DATA_W +: DATA_W]  = a;
      disp_val2[l*DATA_W +: DATA_W]  = b;
      disp_dst_tag[l*TAG_W +: TAG_W] = dtag;
      disp_dst[l*5 +: 5]             = 5'(dtag) ^ 5'h15;
   endtask

   task automatic set_cdb(input int b, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
      cdb_we[b] = 1'b1;
      cdb_tag[b*TAG_W +: TAG_W]   = t;
      cdb_val[b*DATA_W +: DATA_W] = v;
   endtask

   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      idle();
      for (int l = 0; l < 2; l++)
         if ($urandom_range(0, 1) == 1)
            set_lane(l, 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom,
                     TAG_W'($urandom_range(0, 31)));
      for (int b = 0; b < NUM_CDB; b++)
         if ($urandom_range(0, 9) < 3)
            set_cdb(b, TAG_W'($urandom_range(0, 7)), $urandom);
      iss_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 2);
   endtask

   // Asynchronous reset in the middle of a cycle while traffic is live.
   task automatic mid_reset();
      rand_inputs();
      iss_ready = 1'b1;
      #3 reset = 1'b0;
      #1;
      chk("midrst_occ",   64'(occupancy), 64'd0);
      chk("midrst_valid", 64'(iss_valid), 64'd0);
      chk("midrst_stall", 64'(stall),     64'd0);
      m_q.delete();
      stat_q.delete();
      iss_q.delete();
      @(negedge clk);
      chk("midrst_hold_occ", 64'(occupancy), 64'd0);
      reset = 1'b1;
   endtask

   // Monitor: compares the DUT against the records the driver pushed.
   initial begin
      stat_t s;
      ent_t  e;
      forever begin
         @(negedge clk);
         #2;
         if (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            chk("iss_valid", 64'(iss_valid), 64'(s.valid));
            chk("occupancy", 64'(occupancy), 64'(s.occ));
            chk("stall",     64'(stall),     64'(s.stall));
            if (s.valid && iss_valid) begin
               chk("pres_dtag", 64'(iss_dst_tag), 64'(s.dtag));
               chk("pres_dst",  64'(iss_dst),     64'(s.dst));
               chk("pres_val1", 64'(iss_val1),    64'(s.a));
               chk("pres_val2", 64'(iss_val2),    64'(s.b));
            end
            if (iss_valid && iss_ready && !flush) begin
               checks++;
               if (iss_q.size() == 0) begin
                  failures++;
                  $display("FAIL issue_unexpected actual=dtag 0x%0h required=no issue at %0t",
                           iss_dst_tag, $time);
               end else begin
                  e = iss_q.pop_front();
                  chk("issue_dtag", 64'(iss_dst_tag), 64'(e.dtag));
                  chk("issue_val1", 64'(iss_val1),    64'(e.a));
                  chk("issue_val2", 64'(iss_val2),    64'(e.b));
                  $display("issue dtag=%0d dst=%0d val1=%08h val2=%08h occ=%0d",
                           iss_dst_tag, iss_dst, iss_val1, iss_val2, occupancy);
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      idle();
      #2;
      chk("rst_occ",   64'(occupancy),   64'd0);
      chk("rst_valid", 64'(iss_valid),   64'd0);
      chk("rst_stall", 64'(stall),       64'd0);
      chk("rst_dtag",  64'(iss_dst_tag), 64'd0);
      chk("rst_val1",  64'(iss_val1),    64'd0);
      chk("rst_val2",  64'(iss_val2),    64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Two ready ops, tags 3 then 4, issue on consecutive cycles.
      idle();
      set_lane(0, 1'b1, 0, 32'hA0, 1'b1, 0, 32'hA1, 3);
      set_lane(1, 1'b1, 0, 32'hB0, 1'b1, 0, 32'hB1, 4);
      iss_ready = 1'b1;
      step();
      repeat (3) begin idle(); iss_ready = 1'b1; step(); end

      // Older op waits on tag 7, woken by bus 2; it issues before the younger ready op.
      idle(); set_lane(0, 1'b0, 7, 32'h0, 1'b1, 0, 32'h22, 5); step();
      idle(); set_lane(0, 1'b1, 0, 32'h33, 1'b1, 0, 32'h44, 6); step();
      idle(); set_cdb(2, 7, 32'hDEAD); step();
      repeat (3) begin idle(); iss_ready = 1'b1; step(); end

      // Two ready entries held with iss_ready low, then released.
      idle();
      set_lane(0, 1'b1, 0, 32'h81, 1'b1, 0, 32'h82, 8);
      set_lane(1, 1'b1, 0, 32'h91, 1'b1, 0, 32'h92, 9);
      step();
      repeat (4) begin idle(); step(); end
      repeat (3) begin idle(); iss_ready = 1'b1; step(); end

      // Fill to DEPTH-1 with waiting ops, try to dispatch while stalled,
      // wake them, issue two, then flush with dispatch and issue active.
      for (int c = 0; c < 3; c++) begin
         idle();
         set_lane(0, 1'b0, 20, 32'h0, 1'b1, 0, 32'h100 + c, TAG_W'(10 + 2*c));
         set_lane(1, 1'b0, 20, 32'h0, 1'b1, 0, 32'h200 + c, TAG_W'(11 + 2*c));
         step();
      end
      idle(); set_lane(1, 1'b0, 20, 32'h0, 1'b1, 0, 32'h300, 16); step();
      repeat (2) begin
         idle();
         set_lane(0, 1'b1, 0, 32'h1, 1'b1, 0, 32'h2, 30);
         set_lane(1, 1'b1, 0, 32'h3, 1'b1, 0, 32'h4, 31);
         step();
      end
      idle(); set_cdb(0, 20, 32'hBEEF); step();
      repeat (2) begin idle(); iss_ready = 1'b1; step(); end
      idle();
      set_lane(0, 1'b1, 0, 32'h5, 1'b1, 0, 32'h6, 28);
      set_lane(1, 1'b1, 0, 32'h7, 1'b1, 0, 32'h8, 29);
      iss_ready = 1'b1; flush = 1'b1;
      step();
      repeat (2) begin idle(); iss_ready = 1'b1; step(); end

      // Dispatch an operand waiting on tag 9 while tag 9 is broadcast.
      idle();
      set_lane(0, 1'b0, 9, 32'h0, 1'b1, 0, 32'h66, 17);
      set_cdb(1, 9, 32'h55);
      iss_ready = 1'b1;
      step();
      repeat (2) begin idle(); iss_ready = 1'b1; step(); end
      idle(); flush = 1'b1; step();
      idle(); step();

      // Randomized traffic with a reset in the middle.
      for (int c = 0; c < 1500; c++) begin
         if (c == 700) mid_reset();
         rand_inputs();
         step();
      end

      idle();
      #3;
      chk("issue_queue_drained", 64'(iss_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_param.md
RS_PARAM -- requirements
Module: rs_param

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, minimum 4.
REQ-002 Parameter TAG_W, default 5, rename-tag width.
REQ-003 Parameter DATA_W, default 32, operand width.
REQ-004 Parameter NUM_CDB, default 4, number of result-broadcast buses.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-007 disp_en  in  2  per-lane dispatch request; lane 0 is program-older than lane 1.
REQ-008 disp_v1, disp_v2  in  2 each  per-lane operand-ready flags.
REQ-009 disp_tag1, disp_tag2  in  2*TAG_W each  per-lane source tags.
REQ-010 disp_dst  in  2*5  per-lane architectural destination register.
REQ-011 disp_dst_tag  in  2*TAG_W  per-lane destination tag.
REQ-012 disp_val1, disp_val2  in  2*DATA_W each  per-lane operand values.
REQ-013 cdb_we  in  NUM_CDB  per-bus broadcast valid.
REQ-014 cdb_tag  in  NUM_CDB*TAG_W  broadcast tags.
REQ-015 cdb_val  in  NUM_CDB*DATA_W  broadcast values.
REQ-016 flush  in  1  synchronous squash of all entries.
REQ-017 iss_valid  out  1  an issue candidate is presented.
REQ-018 iss_ready  in  1  functional unit accepts the candidate.
REQ-019 iss_dst  out  5, iss_dst_tag  out  TAG_W, iss_val1  out  DATA_W, iss_val2  out  DATA_W  issued entry fields.
REQ-020 stall  out  1  fewer than two free entries.
REQ-021 occupancy  out  $clog2(DEPTH)+1  busy-entry count.

Function
REQ-022 stall SHALL be combinational: occupancy > DEPTH-2.
REQ-023 When stall=0 and flush=0, each enabled lane SHALL be written into a distinct free entry (lowest free index first, lane 0 first); when only lane 1 is enabled it SHALL take the lowest free index.
REQ-024 When stall=1, disp_en SHALL be ignored; upstream holds the instructions.
REQ-025 Each entry SHALL carry an age rank; lane 0 SHALL be older than lane 1 of the same cycle, and every existing entry older than both.
REQ-026 Each cycle, every busy entry with v1=0 (v2=0) SHALL capture cdb_val and set v1 (v2) when any cdb_we bit is set with a matching cdb_tag; on multiple matches the lowest bus index wins.
REQ-027 iss_valid SHALL be asserted combinationally when any busy entry has v1=v2=1; iss_* SHALL present the oldest such entry.
REQ-028 An entry written this cycle SHALL NOT be issue-eligible before the next cycle.
REQ-029 On iss_valid=1 and iss_ready=1, the presented entry SHALL be freed at the clock edge; iss_* outputs SHALL remain stable while iss_valid=1 and iss_ready=0, unless an older entry becomes ready.
REQ-030 occupancy SHALL update by dispatched count minus issued count; simultaneous dispatch of 2 and issue of 1 nets +1.
REQ-031 A freed entry SHALL NOT be reallocated in the same cycle.
REQ-032 flush=1 SHALL clear all busy bits and occupancy at the next edge; dispatch and issue handshake in that cycle SHALL be ignored.

Reset
REQ-033 With reset=0: all busy and v-flags cleared, ranks zeroed, occupancy=0, iss_valid=0, stall=0, iss_* = 0.
REQ-034 Reset assertion mid-operation SHALL discard all entries without completing an in-flight issue.

Configuration
REQ-035 Macro RS_BYPASS_EN: when defined, a dispatched operand with v=0 whose tag matches a same-cycle broadcast SHALL be written with v=1 and the broadcast value; when undefined, it SHALL be written with v=0 unchanged, and the rename stage is responsible for same-cycle forwarding.

Verification
REQ-036 Dispatch two ready ops (dst_tag 3, 4) into an empty station, iss_ready=1 -> tag 3 issues cycle+1, tag 4 cycle+2, occupancy 2->1->0.
REQ-037 Dispatch op A (tag1=7, v1=0) then ready op B; broadcast tag 7 val 0xDEAD on cdb bus 2 -> A's val1=0xDEAD, A issues before B (older).
REQ-038 Fill to DEPTH-1 -> stall=1, dispatch ignored, occupancy unchanged; one issue -> stall=0.
REQ-039 Hold iss_ready=0 with two ready entries for 3 cycles -> iss_* stable, no entry freed; raise iss_ready -> oldest freed.
REQ-040 Dispatch operand tag 9 v=0 concurrent with cdb tag 9 val 0x55 -> with RS_BYPASS_EN, issue next cycle with val 0x55; without, entry remains waiting.
REQ-041 Assert flush with 5 busy entries and dispatch active -> occupancy=0, iss_valid=0 next cycle.
